// File: rtl/lieat_axi_xbar.sv
// lieat_axi_xbar
// ----------------------------------------------------------------------------
// One-master to NSLV-slave AXI4 crossbar with a per-slave address map.
// Read and write paths are independent FSMs that can run at the same time.
// Each path has one transaction outstanding. The address phase is registered,
// which adds one cycle. Data and response beats pass through combinationally
// from the slave latched at the address handshake. Addresses that hit no slave
// are completed locally with DECERR (2'b11).
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. Once a source raises valid, it holds
// valid and its payload stable until that edge.
//
// Ports:
//   clock, reset             clock, synchronous active-high reset
//   m_aw*, m_w*, m_b*        master write address / data / response
//   m_ar*, m_r*              master read address / data
//   s_*                      flattened slave ports, slave i at [i*w +: w]
//   dbg_rstate, dbg_wstate   current read / write FSM state
//
// Decode: slave i hits when (addr & MASK[i]) == BASE[i]. The lowest hit index
// wins. When no slave hits, the error path is taken.
// ----------------------------------------------------------------------------
module lieat_axi_xbar #(
    parameter int NSLV = 2,
    parameter int AW   = 32,
    parameter int DW   = 64,
    parameter int IDW  = 4,
    parameter logic [NSLV*AW-1:0] BASE = '0,
    parameter logic [NSLV*AW-1:0] MASK = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    // master write address
    input  logic                   m_awvalid,
    output logic                   m_awready,
    input  logic [AW-1:0]          m_awaddr,
    input  logic [IDW-1:0]         m_awid,
    input  logic [7:0]             m_awlen,
    input  logic [2:0]             m_awsize,
    input  logic [1:0]             m_awburst,
    // master write data
    input  logic                   m_wvalid,
    output logic                   m_wready,
    input  logic [DW-1:0]          m_wdata,
    input  logic [DW/8-1:0]        m_wstrb,
    input  logic                   m_wlast,
    // master write response
    output logic                   m_bvalid,
    input  logic                   m_bready,
    output logic [1:0]             m_bresp,
    output logic [IDW-1:0]         m_bid,
    // master read address
    input  logic                   m_arvalid,
    output logic                   m_arready,
    input  logic [AW-1:0]          m_araddr,
    input  logic [IDW-1:0]         m_arid,
    input  logic [7:0]             m_arlen,
    input  logic [2:0]             m_arsize,
    input  logic [1:0]             m_arburst,
    // master read data
    output logic                   m_rvalid,
    input  logic                   m_rready,
    output logic [DW-1:0]          m_rdata,
    output logic [1:0]             m_rresp,
    output logic                   m_rlast,
    output logic [IDW-1:0]         m_rid,
    // slave write address
    output logic [NSLV-1:0]        s_awvalid,
    input  logic [NSLV-1:0]        s_awready,
    output logic [NSLV*AW-1:0]     s_awaddr,
    output logic [NSLV*IDW-1:0]    s_awid,
    output logic [NSLV*8-1:0]      s_awlen,
    output logic [NSLV*3-1:0]      s_awsize,
    output logic [NSLV*2-1:0]      s_awburst,
    // slave write data
    output logic [NSLV-1:0]        s_wvalid,
    input  logic [NSLV-1:0]        s_wready,
    output logic [NSLV*DW-1:0]     s_wdata,
    output logic [NSLV*DW/8-1:0]   s_wstrb,
    output logic [NSLV-1:0]        s_wlast,
    // slave write response
    input  logic [NSLV-1:0]        s_bvalid,
    output logic [NSLV-1:0]        s_bready,
    input  logic [NSLV*2-1:0]      s_bresp,
    input  logic [NSLV*IDW-1:0]    s_bid,
    // slave read address
    output logic [NSLV-1:0]        s_arvalid,
    input  logic [NSLV-1:0]        s_arready,
    output logic [NSLV*AW-1:0]     s_araddr,
    output logic [NSLV*IDW-1:0]    s_arid,
    output logic [NSLV*8-1:0]      s_arlen,
    output logic [NSLV*3-1:0]      s_arsize,
    output logic [NSLV*2-1:0]      s_arburst,
    // slave read data
    input  logic [NSLV-1:0]        s_rvalid,
    output logic [NSLV-1:0]        s_rready,
    input  logic [NSLV*DW-1:0]     s_rdata,
    input  logic [NSLV*2-1:0]      s_rresp,
    input  logic [NSLV-1:0]        s_rlast,
    input  logic [NSLV*IDW-1:0]    s_rid,
    // debug
    output logic [1:0]             dbg_rstate,
    output logic [2:0]             dbg_wstate
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE, R_ADDR, R_DATA, R_ERR
    } r_state_t;

    typedef enum logic [2:0] {
        W_IDLE, W_ADDR, W_DATA, W_RESP, W_EDATA, W_ERESP
    } w_state_t;

    // Returns {hit, index}. Scanning from the top down lets the lowest
    // matching index overwrite any higher one.
    function automatic logic [SW:0] decode(input logic [AW-1:0] addr);
        logic          hit;
        logic [SW-1:0] idx;
        hit = 1'b0;
        idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit = 1'b1;
                idx = SW'(i);
            end
        end
        return {hit, idx};
    endfunction

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    r_state_t        r_state, r_next;
    logic [SW-1:0]   r_sel;
    logic [AW-1:0]   r_addr;
    logic [IDW-1:0]  r_id;
    logic [7:0]      r_len;
    logic [2:0]      r_size;
    logic [1:0]      r_burst;
    logic [7:0]      r_cnt;
    logic [SW:0]     ar_dec;
    logic            ar_hs;

    assign ar_dec = decode(m_araddr);
    assign ar_hs  = m_arvalid && m_arready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_sel   <= '0;
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_sel   <= ar_dec[SW-1:0];
                r_addr  <= m_araddr;
                r_id    <= m_arid;
                r_len   <= m_arlen;
                r_size  <= m_arsize;
                r_burst <= m_arburst;
                r_cnt   <= '0;
            end else if (r_state == R_ERR && m_rvalid && m_rready) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        r_next    = r_state;
        m_arready = 1'b0;
        s_arvalid = '0;
        s_rready  = '0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        m_rid     = '0;
        if (!reset) begin
            case (r_state)
                R_IDLE: begin
                    m_arready = 1'b1;
                    if (m_arvalid) begin
                        r_next = ar_dec[SW] ? R_ADDR : R_ERR;
                    end
                end
                R_ADDR: begin
                    s_arvalid[r_sel] = 1'b1;
                    if (s_arready[r_sel]) begin
                        r_next = R_DATA;
                    end
                end
                R_DATA: begin
                    m_rvalid        = s_rvalid[r_sel];
                    m_rdata         = s_rdata[int'(r_sel)*DW +: DW];
                    m_rresp         = s_rresp[int'(r_sel)*2 +: 2];
                    m_rlast         = s_rlast[r_sel];
                    m_rid           = s_rid[int'(r_sel)*IDW +: IDW];
                    s_rready[r_sel] = m_rready;
                    if (s_rvalid[r_sel] && m_rready && s_rlast[r_sel]) begin
                        r_next = R_IDLE;
                    end
                end
                R_ERR: begin
                    m_rvalid = 1'b1;
                    m_rresp  = RESP_DECERR;
                    m_rid    = r_id;
                    m_rlast  = (r_cnt == r_len);
                    if (m_rready && (r_cnt == r_len)) begin
                        r_next = R_IDLE;
                    end
                end
                default: r_next = R_IDLE;
            endcase
        end
    end

    // Address payload comes from registers, so it is broadcast; only the
    // selected slave ever sees valid.
    assign s_araddr  = {NSLV{r_addr}};
    assign s_arid    = {NSLV{r_id}};
    assign s_arlen   = {NSLV{r_len}};
    assign s_arsize  = {NSLV{r_size}};
    assign s_arburst = {NSLV{r_burst}};

    // ------------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------------
    w_state_t        w_state, w_next;
    logic [SW-1:0]   w_sel;
    logic [AW-1:0]   w_addr;
    logic [IDW-1:0]  w_id;
    logic [7:0]      w_len;
    logic [2:0]      w_size;
    logic [1:0]      w_burst;
    logic [SW:0]     aw_dec;
    logic            aw_hs;

    assign aw_dec = decode(m_awaddr);
    assign aw_hs  = m_awvalid && m_awready;

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_sel   <= '0;
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_sel   <= aw_dec[SW-1:0];
                w_addr  <= m_awaddr;
                w_id    <= m_awid;
                w_len   <= m_awlen;
                w_size  <= m_awsize;
                w_burst <= m_awburst;
            end
        end
    end

    always_comb begin
        w_next    = w_state;
        m_awready = 1'b0;
        s_awvalid = '0;
        m_wready  = 1'b0;
        s_wvalid  = '0;
        s_bready  = '0;
        m_bvalid  = 1'b0;
        m_bresp   = '0;
        m_bid     = '0;
        if (!reset) begin
            case (w_state)
                W_IDLE: begin
                    m_awready = 1'b1;
                    if (m_awvalid) begin
                        w_next = aw_dec[SW] ? W_ADDR : W_EDATA;
                    end
                end
                W_ADDR: begin
                    s_awvalid[w_sel] = 1'b1;
                    if (s_awready[w_sel]) begin
                        w_next = W_DATA;
                    end
                end
                W_DATA: begin
                    s_wvalid[w_sel] = m_wvalid;
                    m_wready        = s_wready[w_sel];
                    if (m_wvalid && s_wready[w_sel] && m_wlast) begin
                        w_next = W_RESP;
                    end
                end
                W_RESP: begin
                    m_bvalid        = s_bvalid[w_sel];
                    m_bresp         = s_bresp[int'(w_sel)*2 +: 2];
                    m_bid           = s_bid[int'(w_sel)*IDW +: IDW];
                    s_bready[w_sel] = m_bready;
                    if (s_bvalid[w_sel] && m_bready) begin
                        w_next = W_IDLE;
                    end
                end
                W_EDATA: begin
                    // Unmapped write: swallow beats until the last one.
                    m_wready = 1'b1;
                    if (m_wvalid && m_wlast) begin
                        w_next = W_ERESP;
                    end
                end
                W_ERESP: begin
                    m_bvalid = 1'b1;
                    m_bresp  = RESP_DECERR;
                    m_bid    = w_id;
                    if (m_bready) begin
                        w_next = W_IDLE;
                    end
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    assign s_awaddr  = {NSLV{w_addr}};
    assign s_awid    = {NSLV{w_id}};
    assign s_awlen   = {NSLV{w_len}};
    assign s_awsize  = {NSLV{w_size}};
    assign s_awburst = {NSLV{w_burst}};

    // Write data payload is broadcast; s_wvalid gates it to the selected slave.
    assign s_wdata = {NSLV{m_wdata}};
    assign s_wstrb = {NSLV{m_wstrb}};
    assign s_wlast = {NSLV{m_wlast}};

    assign dbg_rstate = r_state;
    assign dbg_wstate = w_state;

endmodule
